alu_mul_seq: RTL

Multi-cycle shift-add multiplier that sits on the driving end of the ALU interface (alu_if, tb modport) and issues op/a/b itself.
- Uses the existing single-cycle combinational ALU for every add and every multiplicand shift; only the multiplier right-shift and the bit counter are local.
- Produces the low 32 bits of an unsigned 32x32 product (MIPS-style MUL) behind a start/done handshake.
- Sits beside the execute stage; the stage holds the pipeline while busy=1.

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/alu_if.sv | 24 ++
 rtl/alu.sv | 47 ++++
 rtl/alu_mul_seq.sv | 118 +++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, ALU opcodes and the sequential multiplier FSM states.
// MUL_CNT_W sizes the multiplier bit counter for a 32-bit word.
package cpu_types_pkg;

   localparam int WORD_W    = 32;
   localparam int MUL_CNT_W = 5;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_SRA  = 4'd2,
      ALU_ADD  = 4'd3,
      ALU_SUB  = 4'd4,
      ALU_AND  = 4'd5,
      ALU_OR   = 4'd6,
      ALU_XOR  = 4'd7,
      ALU_NOR  = 4'd8,
      ALU_SLT  = 4'd9,
      ALU_SLTU = 4'd10
   } aluop_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } mulstate_t;

endpackage

// File: rtl/alu_if.sv
// ALU request/result bundle. Handshake: none -- out and flags are combinational
// from op/a/b within the same cycle; the tb side owns op/a/b, the alu side owns out/flags.
interface alu_if;
   import cpu_types_pkg::*;

   aluop_t op;
   word_t  a;
   word_t  b;
   word_t  out;
   logic   zero_flag;
   logic   negative_flag;
   logic   overflow_flag;

   modport alu (
      input  op, a, b,
      output out, zero_flag, negative_flag, overflow_flag
   );

   modport tb (
      output op, a, b,
      input  out, zero_flag, negative_flag, overflow_flag
   );

endinterface

// File: rtl/alu.sv
// Single-cycle combinational ALU serving alu_if; overflow is signed overflow
// of ADD/SUB only, zero/negative reflect the result word.
module alu
   import cpu_types_pkg::*;
(
   alu_if.alu aluif
);

   word_t      res;
   logic       ovf;
   logic [4:0] shamt;

   assign shamt = aluif.b[4:0];

   always_comb begin
      res = '0;
      ovf = 1'b0;
      case (aluif.op)
         ALU_SLL:  res = aluif.a << shamt;
         ALU_SRL:  res = aluif.a >> shamt;
         ALU_SRA:  res = word_t'($signed(aluif.a) >>> shamt);
         ALU_ADD: begin
            res = aluif.a + aluif.b;
            ovf = (aluif.a[WORD_W-1] == aluif.b[WORD_W-1]) &&
                  (res[WORD_W-1] != aluif.a[WORD_W-1]);
         end
         ALU_SUB: begin
            res = aluif.a - aluif.b;
            ovf = (aluif.a[WORD_W-1] != aluif.b[WORD_W-1]) &&
                  (res[WORD_W-1] != aluif.a[WORD_W-1]);
         end
         ALU_AND:  res = aluif.a & aluif.b;
         ALU_OR:   res = aluif.a | aluif.b;
         ALU_XOR:  res = aluif.a ^ aluif.b;
         ALU_NOR:  res = ~(aluif.a | aluif.b);
         ALU_SLT:  res = {{(WORD_W-1){1'b0}}, ($signed(aluif.a) < $signed(aluif.b))};
         ALU_SLTU: res = {{(WORD_W-1){1'b0}}, (aluif.a < aluif.b)};
         default:  res = '0;
      endcase
   end

   assign aluif.out           = res;
   assign aluif.overflow_flag = ovf;
   assign aluif.zero_flag     = (res == '0);
   assign aluif.negative_flag = res[WORD_W-1];

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier (low 32 bits of unsigned product) that borrows the shared ALU
// for every add and multiplicand shift. Define MUL_EARLY_EXIT_EN to stop once no multiplier bits remain.
module alu_mul_seq
   import cpu_types_pkg::*;
#(
   parameter int WIDTH = WORD_W
)(
   input  logic      CLK,
   input  logic      nRST,
   input  logic      start,
   input  word_t     mcand,
   input  word_t     mplier,
   output logic      busy,
   output logic      done,
   output word_t     product,
   output mulstate_t dbg_state,
   alu_if.tb         aluif
);

   localparam logic [MUL_CNT_W-1:0] LAST_CNT = MUL_CNT_W'(WIDTH-1);

   mulstate_t            state_q, state_d;
   word_t                acc_q, acc_d;
   word_t                mc_q, mc_d;
   word_t                mp_q, mp_d;
   word_t                product_q, product_d;
   logic [MUL_CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         mc_q      <= '0;
         mp_q      <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mc_q      <= mc_d;
         mp_q      <= mp_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mc_d      = mc_q;
      mp_d      = mp_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      aluif.op  = ALU_ADD;
      aluif.a   = '0;
      aluif.b   = '0;
      busy      = 1'b0;
      done      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               mc_d  = mcand;
               mp_d  = mplier;
               acc_d = '0;
               cnt_d = '0;
`ifdef MUL_EARLY_EXIT_EN
               if (mplier == '0)
                  state_d = DONE;
               else
`endif
               state_d = mplier[0] ? ADD : SHIFT;
            end
         end

         ADD: begin
            busy     = 1'b1;
            aluif.op = ALU_ADD;
            aluif.a  = acc_q;
            aluif.b  = mc_q;
            acc_d    = aluif.out;
            state_d  = SHIFT;
         end

         SHIFT: begin
            busy     = 1'b1;
            aluif.op = ALU_SLL;
            aluif.a  = mc_q;
            aluif.b  = word_t'(1);
            mc_d     = aluif.out;
            mp_d     = mp_q >> 1;
            cnt_d    = cnt_q + MUL_CNT_W'(1);
            // mp_q[1] is the bit that becomes the LSB after this shift.
            if (cnt_q == LAST_CNT)
               state_d = DONE;
`ifdef MUL_EARLY_EXIT_EN
            else if ((mp_q >> 1) == '0)
               state_d = DONE;
`endif
            else
               state_d = mp_q[1] ? ADD : SHIFT;
         end

         DONE: begin
            done      = 1'b1;
            product_d = acc_q;
            state_d   = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // Bypass so the result is already visible during the DONE pulse.
   assign product   = (state_q == DONE) ? acc_q : product_q;
   assign dbg_state = state_q;

endmodule
